// File: rtl/mux_n_pipe.sv
`default_nettype none
// ============================================================================
// Module      : mux_n_pipe
// Description : N:1 WIDTH-bit valid/ready multiplexer with a registered output
//               slot; explicit-select or round-robin grant. Optional output
//               handshake counter enabled by defining MUX_XFER_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_n_pipe #(
    parameter  int WIDTH = 32,
    parameter  int N     = 4,
    localparam int SELW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_src,
    output logic               out_valid,
    input  logic               out_ready
`ifdef MUX_XFER_CNT_EN
    ,
    output logic [31:0]        xfer_cnt
`endif
);

    logic [WIDTH-1:0] r_data;
    logic [SELW-1:0]  r_src;
    logic             r_valid;
    logic [SELW-1:0]  r_rr_ptr;

    logic             w_load;
    logic             w_sel_ok;
    logic [SELW-1:0]  w_rr_start;
    logic [2*N-1:0]   w_rr_dbl;
    logic [N-1:0]     w_rr_rot;
    logic [SELW-1:0]  w_rr_off;
    logic [SELW:0]    w_rr_sum;
    logic             w_rr_any;
    logic [SELW-1:0]  w_rr_idx;
    logic             w_gnt_any;
    logic [SELW-1:0]  w_gnt_idx;
    logic [WIDTH-1:0] w_gnt_data;
    logic             w_xfer;

    assign w_load = !r_valid || out_ready;

    always_comb begin
        w_sel_ok = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (sel == SELW'(i)) w_sel_ok = 1'b1;
        end
    end

    // Rotate valids so bit 0 is the channel just after the last winner.
    assign w_rr_start = (r_rr_ptr == SELW'(N - 1)) ? '0 : r_rr_ptr + 1'b1;
    assign w_rr_dbl   = {in_valid, in_valid} >> w_rr_start;
    assign w_rr_rot   = w_rr_dbl[N-1:0];
    assign w_rr_any   = |w_rr_rot;

    always_comb begin
        w_rr_off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rr_rot[k]) w_rr_off = SELW'(k);
        end
    end

    always_comb begin
        w_rr_sum = {1'b0, w_rr_start} + {1'b0, w_rr_off};
        if (w_rr_sum >= (SELW+1)'(N)) w_rr_sum = w_rr_sum - (SELW+1)'(N);
        w_rr_idx = w_rr_sum[SELW-1:0];
    end

    assign w_gnt_any = mode ? w_rr_any : w_sel_ok;
    assign w_gnt_idx = mode ? w_rr_idx : sel;

    always_comb begin
        in_ready   = '0;
        w_gnt_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_gnt_idx == SELW'(i)) begin
                in_ready[i] = w_load && w_gnt_any;
                w_gnt_data  = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_xfer = |(in_valid & in_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data   <= '0;
            r_src    <= '0;
            r_valid  <= 1'b0;
            r_rr_ptr <= SELW'(N - 1);
        end else if (w_load) begin
            if (w_xfer) begin
                r_data  <= w_gnt_data;
                r_src   <= w_gnt_idx;
                r_valid <= 1'b1;
                if (mode) r_rr_ptr <= w_gnt_idx;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_data;
    assign out_src   = r_src;
    assign out_valid = r_valid;

`ifdef MUX_XFER_CNT_EN
    logic [31:0] r_xfer_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xfer_cnt <= '0;
        end else if (r_valid && out_ready) begin
            r_xfer_cnt <= r_xfer_cnt + 32'd1;
        end
    end

    assign xfer_cnt = r_xfer_cnt;
`endif

endmodule
`default_nettype wire

// File: doc/mux_n_pipe.md
Name: mux_n_pipe

Overview:
- Parametrised N:1, WIDTH-bit multiplexer with a registered output stage and valid/ready handshakes on every input channel and on the output.
- Generalises the datapath 2:1 select to N sources. Adds two modes: an explicit select, or round-robin arbitration among valid sources.
- Sits between producer stages (ALU result, load data, immediate, PC+4) and a consumer stage of the 32-bit RISC pipeline.
- Exactly one transfer per cycle at full throughput.

Parameters:
- WIDTH, 32, data width of each channel and of the output.
- N, 4, number of input channels; legal range 2..16.
- SELW, derived localparam = clog2(N), select and source-index width; not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; combinational.
- mode  input  1  0 = explicit select, 1 = round-robin.
- sel  input  SELW  channel index, used when mode=0.
- out_data  output  WIDTH  registered selected data.
- out_src  output  SELW  registered index of the channel that supplied out_data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  consumer ready.

Behaviour:
- Interface: one clock, clk. Reset is rst_n, asynchronous and active-low.
- Reset values: out_valid=0, out_data=0, out_src=0, rr_ptr=N-1. With rr_ptr=N-1, channel 0 has top priority after reset.
- Reset mid-operation: an asserted rst_n clears all state immediately. Any held output word is dropped; no partial state survives.
- Load enable: load = !out_valid || out_ready. The output slot is free, or it is being drained this cycle.
- Grant, mode=0:
  - grant = onehot(sel) when sel < N.
  - sel >= N grants nothing: in_ready all 0 and no load.
- Grant, mode=1:
  - Search in_valid starting at (rr_ptr+1) mod N, wrapping, for the first set bit.
  - grant = that bit. If no valid, there is no grant.
- in_ready[i] = load && grant[i]. No combinational dependency of in_ready on in_valid in mode=0. In mode=1, in_ready depends on in_valid only through the arbiter.
- Transfer on channel i: in_valid[i] && in_ready[i].
  - Next edge: out_data <= channel i data, out_src <= i, out_valid <= 1.
  - In mode=1 only, rr_ptr <= i.
- No transfer while load=1: out_valid <= 0 at the next edge. out_data and out_src hold their last values.
- Stall (out_valid=1, out_ready=0):
  - out_data, out_src and out_valid hold.
  - All in_ready=0.
  - rr_ptr holds.
- Latency: 1 cycle from input handshake to out_valid.
- Throughput: 1 word/cycle with out_ready held high.
- Simultaneous drain and fill: when out_valid=1, out_ready=1 and an input is granted, the new word replaces the old one at the same edge. out_valid stays 1.
- rr_ptr updates only on an accepted transfer. A waiting valid channel is served within N transfers, so there is no starvation.
- Mode or sel change: takes effect on the grant in the same cycle. A word already held at the output is unaffected. rr_ptr is retained across mode=0 periods.
- Inputs must obey valid/ready rules: data stable while valid && !ready. The block does not check this.

Optional Feature:
- Macro: MUX_XFER_CNT_EN.
- Defined:
  - Adds output port xfer_cnt, output, 32 bits.
  - Increments by 1 on every output handshake (out_valid && out_ready) and wraps 0xFFFFFFFF -> 0.
  - Reset value 0.
- Not defined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset: assert rst_n=0 mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_src=0 immediately (asynchronous). The first round-robin grant after release goes to channel 0 when all channels are valid.
- Explicit select: mode=0, sel=2, in_data[2]=0xDEADBEEF valid, out_ready=1 -> in_ready=4'b0100; the next cycle gives out_data=0xDEADBEEF, out_src=2, out_valid=1.
- Invalid select: N=3, sel=3, all valid -> in_ready=0. out_valid drops to 0 after any held word drains.
- Round-robin fairness: mode=1, all 4 channels valid continuously, out_ready=1 -> out_src sequence 0,1,2,3,0,1; one word per cycle.
- Backpressure: out_valid=1 with 0x11, out_ready=0 for 3 cycles, then 1 -> out_data holds 0x11 and in_ready=0 during the stall. The next word appears one cycle after out_ready rises, with no bubble and no loss.
- Sparse round-robin plus counter: with MUX_XFER_CNT_EN defined, mode=1, only channels 1 and 3 valid, 5 output handshakes -> out_src=1,3,1,3,1 and xfer_cnt=5.
